// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: one outstanding memory read feeding a 2-entry buffer for the decoder.
// Optional macro IFU_PERF_CNT_EN adds the fetch_cnt output (count of instructions handed to decode).
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [5:0]  if_opcode,
  output logic [31:0] if_pc,
  input  logic        id_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
`ifdef IFU_PERF_CNT_EN
  output logic [31:0] fetch_cnt,
`endif
  output logic [1:0]  dbg_state
);

  // Handshakes: a memory request is accepted in a cycle with imem_req && imem_gnt; its
  // response is the next cycle with imem_rvalid. The decoder takes the buffer head in a
  // cycle with if_valid && id_ready; a redirect in that cycle cancels the transfer.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DROP = 2'd3
  } state_e;

  localparam logic [31:0] RESET_PC_AL = {RESET_PC[31:2], 2'b00};
  localparam logic [1:0]  FULL_CNT    = 2'(BUF_DEPTH);

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] instr0_q, instr0_d, pc0_q, pc0_d;
  logic [31:0] instr1_q, instr1_d, pc1_q, pc1_d;
  logic        push, pop;
  logic [1:0]  cnt_after_push;

  assign if_valid  = (cnt_q != 2'd0);
  assign if_instr  = instr0_q;
  assign if_pc     = pc0_q;
  assign if_opcode = instr0_q[31:26];
  assign imem_addr = fetch_pc_q;
  assign dbg_state = state_q;

  assign pop            = if_valid && id_ready && !redirect;
  assign cnt_after_push = cnt_q + 2'd1 - {1'b0, pop};

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    imem_req   = 1'b0;
    push       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (redirect || (!halt && (cnt_q < FULL_CNT))) state_d = S_REQ;
      end
      S_REQ: begin
        imem_req = 1'b1;
        if (imem_gnt) begin
          req_pc_d   = fetch_pc_q;
          fetch_pc_d = fetch_pc_q + 32'd4;
          state_d    = redirect ? S_DROP : S_WAIT;
        end
      end
      S_WAIT: begin
        // A redirect arriving together with the response consumes it, so nothing is left to drop.
        if (imem_rvalid) begin
          push = !redirect;
          if (redirect || (!halt && (cnt_after_push < FULL_CNT))) state_d = S_REQ;
          else                                                     state_d = S_IDLE;
        end else if (redirect) begin
          state_d = S_DROP;
        end
      end
      S_DROP: begin
        if (imem_rvalid) state_d = S_REQ;
      end
      default: state_d = S_IDLE;
    endcase
    if (redirect) fetch_pc_d = redirect_pc & 32'hFFFF_FFFC;
  end

  // Entry 0 is always the head, so a pop shifts entry 1 down.
  always_comb begin
    cnt_d    = cnt_q;
    instr0_d = instr0_q;
    pc0_d    = pc0_q;
    instr1_d = instr1_q;
    pc1_d    = pc1_q;
    if (redirect) begin
      cnt_d = 2'd0;
    end else begin
      case ({push, pop})
        2'b01: begin
          instr0_d = instr1_q;
          pc0_d    = pc1_q;
          cnt_d    = cnt_q - 2'd1;
        end
        2'b10: begin
          if (cnt_q == 2'd0) begin
            instr0_d = imem_rdata;
            pc0_d    = req_pc_q;
          end else begin
            instr1_d = imem_rdata;
            pc1_d    = req_pc_q;
          end
          cnt_d = cnt_q + 2'd1;
        end
        2'b11: begin
          if (cnt_q == 2'd1) begin
            instr0_d = imem_rdata;
            pc0_d    = req_pc_q;
          end else begin
            instr0_d = instr1_q;
            pc0_d    = pc1_q;
            instr1_d = imem_rdata;
            pc1_d    = req_pc_q;
          end
        end
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC_AL;
      req_pc_q   <= '0;
      cnt_q      <= '0;
      instr0_q   <= '0;
      pc0_q      <= '0;
      instr1_q   <= '0;
      pc1_q      <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      cnt_q      <= cnt_d;
      instr0_q   <= instr0_d;
      pc0_q      <= pc0_d;
      instr1_q   <= instr1_d;
      pc1_q      <= pc1_d;
    end
  end

`ifdef IFU_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    if (pop) fetch_cnt_d = fetch_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fetch_cnt_q <= '0;
    else        fetch_cnt_q <= fetch_cnt_d;
  end

  assign fetch_cnt = fetch_cnt_q;
`endif

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL set the first fetch address after reset.
REQ-002 Parameter BUF_DEPTH, default 2, SHALL set the instruction buffer depth; only the value 2 is supported.
REQ-003 CLK  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 RST  input  1  SHALL be the reset, asynchronous and active-low.
REQ-005 imem_req  output  1  SHALL signal an instruction memory read request.
REQ-006 imem_addr  output  32  SHALL give the word-aligned request address; bits [1:0] always 2'b00.
REQ-007 imem_gnt  input  1  SHALL signal that memory accepted the request this cycle.
REQ-008 imem_rvalid  input  1  SHALL signal that read data for the oldest accepted request is present.
REQ-009 imem_rdata  input  32  SHALL carry the instruction word, valid when imem_rvalid=1.
REQ-010 if_valid  output  1  SHALL signal that the buffer head holds an instruction for the decoder.
REQ-011 if_instr  output  32  SHALL carry the buffer-head instruction word.
REQ-012 if_opcode  output  6  SHALL equal if_instr[31:26] and feed the main decoder opcode input.
REQ-013 if_pc  output  32  SHALL carry the buffer-head instruction address.
REQ-014 id_ready  input  1  SHALL signal that the decoder accepts the head this cycle.
REQ-015 redirect  input  1  SHALL request a fetch restart at redirect_pc (taken branch or jump).
REQ-016 redirect_pc  input  32  SHALL give the restart address; bits [1:0] ignored and treated as 2'b00.
REQ-017 halt  input  1  SHALL block new requests while high; the outstanding request completes.

Function
REQ-018 FSM states SHALL be IDLE, REQ, WAIT, DROP.
REQ-019 IDLE->REQ when halt=0 and (buffer count + outstanding) < 2; otherwise stay in IDLE.
REQ-020 In REQ, imem_req SHALL be 1 and imem_addr SHALL hold fetch_pc stable until imem_gnt=1.
REQ-021 REQ with imem_gnt=1 SHALL move to WAIT and set fetch_pc to fetch_pc+4, mod 2^32; wrap from 32'hFFFF_FFFC to 0 is legal.
REQ-022 Only one request SHALL be outstanding; imem_req SHALL be 0 outside REQ.
REQ-023 WAIT with imem_rvalid=1 SHALL push {imem_rdata, request address} into the buffer, then go to REQ if space remains and halt=0, else go to IDLE.
REQ-024 The buffer SHALL be a 2-entry FIFO; if_valid=1 whenever count>0; pop when if_valid and id_ready are both 1.
REQ-025 Push and pop in the same cycle SHALL leave count unchanged; a push SHALL never occur when count=2.
REQ-026 Minimum latency SHALL be 2 cycles from imem_gnt to if_valid, given imem_rvalid the cycle after imem_gnt.
REQ-027 redirect=1 SHALL flush the buffer (count=0, if_valid=0 next cycle) and load fetch_pc with {redirect_pc[31:2],2'b00}.
REQ-028 redirect while in WAIT, or in REQ with imem_gnt=1, SHALL go to DROP; the next imem_rvalid is discarded, then the FSM goes to REQ.
REQ-029 redirect in IDLE, or in REQ with imem_gnt=0, SHALL go to REQ with the new address next cycle; the abandoned address SHALL not be granted.
REQ-030 redirect and pop in the same cycle: redirect wins; redirect and push in the same cycle: the pushed data is discarded.
REQ-031 Outputs of an empty buffer (if_instr, if_pc) SHALL be don't-care; if_opcode SHALL be combinational from if_instr.

Reset
REQ-032 RST low SHALL asynchronously force state=IDLE, fetch_pc=RESET_PC, count=0, drop flag=0, imem_req=0, if_valid=0, if_instr=0, if_pc=0.
REQ-033 A response arriving after reset is released, for a pre-reset request, is outside the protocol; memory SHALL be reset together with this block.

Configuration
REQ-034 Macro IFU_PERF_CNT_EN defined: add output fetch_cnt (32 bits), reset to 0, incremented on each pop, wrapping at 2^32 and not cleared by redirect.
REQ-035 Macro IFU_PERF_CNT_EN undefined: the fetch_cnt port and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-036 Reset release, id_ready=1, memory grants immediately and responds 1 cycle later -> imem_addr sequence 0,4,8; first if_valid at cycle 3, with if_pc=0.
REQ-037 id_ready=0 with a continuous grant -> exactly 2 instructions buffered, imem_req=0 after that, if_pc holds 0 until id_ready=1.
REQ-038 redirect=1 with redirect_pc=32'h0000_0103 while in WAIT -> response dropped, next imem_addr=32'h0000_0100, no stale if_valid.
REQ-039 RESET_PC=32'hFFFF_FFF8 -> fetch addresses FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-040 imem_rdata=32'h8C08_0004 delivered -> if_opcode=6'b100011; with IFU_PERF_CNT_EN defined, fetch_cnt=1 after the pop.
REQ-041 RST asserted mid-WAIT with count=1 -> if_valid=0 and imem_req=0 immediately, without waiting for a clock edge.
